// File: rtl/ball_motion.sv
// Per-frame ball kinematics: serve delay, wall/paddle bounces and miss detection.
// Optional macro BALL_SPEEDUP_EN: every paddle hit raises the step toward SPEED_MAX.
module ball_motion #(
   parameter int X_W         = 10,
   parameter int Y_W         = 10,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int BALL_SIDE   = 8,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_H    = 64,
   parameter int SPEED       = 2,
   parameter int SERVE_DELAY = 60
`ifdef BALL_SPEEDUP_EN
   ,parameter int SPEED_MAX  = 6
`endif
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           new_frame_i,
   input  logic [X_W-1:0] player_paddle_x_i,
   input  logic [Y_W-1:0] player_paddle_y_i,
   input  logic [X_W-1:0] pc_paddle_x_i,
   input  logic [Y_W-1:0] pc_paddle_y_i,
   output logic [X_W-1:0] ball_x_o,
   output logic [Y_W-1:0] ball_y_o,
   output logic           player_score_o,
   output logic           pc_score_o
);

   localparam int XE     = X_W + 1;
   localparam int YE     = Y_W + 1;
   localparam int STEP_W = 8;
   localparam int CNT_W  = $clog2(SERVE_DELAY) + 1;

   localparam logic [X_W-1:0] CENTRE_X = X_W'(H_RES / 2 - BALL_SIDE / 2);
   localparam logic [Y_W-1:0] CENTRE_Y = Y_W'(V_RES / 2 - BALL_SIDE / 2);
   localparam logic [Y_W-1:0] BOTTOM_Y = Y_W'(V_RES - BALL_SIDE);
   localparam logic [XE-1:0]  BS_X     = XE'(BALL_SIDE);
   localparam logic [YE-1:0]  BS_Y     = YE'(BALL_SIDE);
   localparam logic [XE-1:0]  PW_X     = XE'(PADDLE_W);
   localparam logic [YE-1:0]  PH_Y     = YE'(PADDLE_H);
   localparam logic [XE-1:0]  HRES_X   = XE'(H_RES);
   localparam logic [YE-1:0]  VRES_Y   = YE'(V_RES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

   typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0]   ball_x_q, ball_x_d;
   logic [Y_W-1:0]   ball_y_q, ball_y_d;
   logic             dir_x_q, dir_x_d;   // 1 = right
   logic             dir_y_q, dir_y_d;   // 1 = down
   logic             player_score_q, player_score_d;
   logic             pc_score_q, pc_score_d;

`ifdef BALL_SPEEDUP_EN
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(SPEED_MAX);
   logic [STEP_W-1:0] step_q, step_d, step_bump;
   assign step_bump = (step_q >= STEP_MAX) ? STEP_MAX : step_q + STEP_W'(1);
`else
   localparam logic [STEP_W-1:0] step_q = STEP_W'(SPEED);
`endif

   // Widened copies so every compare and sum below is free of wrap-around.
   logic [XE-1:0] x_e, step_x, nx_l, nx_r, ppx, pcx;
   logic [YE-1:0] y_e, step_y, ppy, pcy;
   logic          ov_player, ov_pc, hit_player, hit_pc, miss_left, miss_right;

   assign x_e    = {1'b0, ball_x_q};
   assign y_e    = {1'b0, ball_y_q};
   assign step_x = XE'(step_q);
   assign step_y = YE'(step_q);
   assign nx_l   = x_e - step_x;
   assign nx_r   = x_e + step_x;
   assign ppx    = {1'b0, player_paddle_x_i};
   assign ppy    = {1'b0, player_paddle_y_i};
   assign pcx    = {1'b0, pc_paddle_x_i};
   assign pcy    = {1'b0, pc_paddle_y_i};

   assign ov_player  = (y_e + BS_Y > ppy) && (y_e < ppy + PH_Y);
   assign ov_pc      = (y_e + BS_Y > pcy) && (y_e < pcy + PH_Y);
   assign hit_player = ov_player && (nx_l <= ppx + PW_X) && (nx_l + BS_X > ppx);
   assign hit_pc     = ov_pc && (nx_r + BS_X >= pcx) && (nx_r < pcx + PW_X);
   assign miss_left  = x_e < step_x;
   assign miss_right = x_e + BS_X + step_x > HRES_X;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d        = state_q;
      cnt_d          = cnt_q;
      ball_x_d       = ball_x_q;
      ball_y_d       = ball_y_q;
      dir_x_d        = dir_x_q;
      dir_y_d        = dir_y_q;
      player_score_d = 1'b0;
      pc_score_d     = 1'b0;
`ifdef BALL_SPEEDUP_EN
      step_d         = step_q;
`endif
      unique case (state_q)
         SERVE: begin
            if (new_frame_i) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         PLAY: begin
            if (new_frame_i) begin
               if (dir_y_q) begin
                  if (y_e + BS_Y + step_y >= VRES_Y) begin
                     ball_y_d = BOTTOM_Y;
                     dir_y_d  = 1'b0;
                  end else begin
                     ball_y_d = Y_W'(y_e + step_y);
                  end
               end else begin
                  if (y_e < step_y) begin
                     ball_y_d = '0;
                     dir_y_d  = 1'b1;
                  end else begin
                     ball_y_d = Y_W'(y_e - step_y);
                  end
               end

               // A miss overrides the vertical update computed above.
               if (!dir_x_q) begin
                  if (hit_player) begin
                     ball_x_d = X_W'(ppx + PW_X);
                     dir_x_d  = 1'b1;
`ifdef BALL_SPEEDUP_EN
                     step_d   = step_bump;
`endif
                  end else if (miss_left) begin
                     pc_score_d = 1'b1;
                     state_d    = SCORED;
                     ball_y_d   = ball_y_q;
                     dir_y_d    = dir_y_q;
                  end else begin
                     ball_x_d = X_W'(nx_l);
                  end
               end else begin
                  if (hit_pc) begin
                     ball_x_d = X_W'(pcx - BS_X);
                     dir_x_d  = 1'b0;
`ifdef BALL_SPEEDUP_EN
                     step_d   = step_bump;
`endif
                  end else if (miss_right) begin
                     player_score_d = 1'b1;
                     state_d        = SCORED;
                     ball_y_d       = ball_y_q;
                     dir_y_d        = dir_y_q;
                  end else begin
                     ball_x_d = X_W'(nx_r);
                  end
               end
            end
         end
         SCORED: begin
            ball_x_d = CENTRE_X;
            ball_y_d = CENTRE_Y;
            dir_x_d  = player_score_q;   // serve toward the side that conceded
            dir_y_d  = ~dir_y_q;
            cnt_d    = '0;
            state_d  = SERVE;
`ifdef BALL_SPEEDUP_EN
            step_d   = STEP_W'(SPEED);
`endif
         end
         default: state_d = SERVE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= SERVE;
         cnt_q          <= '0;
         ball_x_q       <= CENTRE_X;
         ball_y_q       <= CENTRE_Y;
         dir_x_q        <= 1'b1;
         dir_y_q        <= 1'b1;
         player_score_q <= 1'b0;
         pc_score_q     <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         step_q         <= STEP_W'(SPEED);
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ball_x_q       <= ball_x_d;
         ball_y_q       <= ball_y_d;
         dir_x_q        <= dir_x_d;
         dir_y_q        <= dir_y_d;
         player_score_q <= player_score_d;
         pc_score_q     <= pc_score_d;
`ifdef BALL_SPEEDUP_EN
         step_q         <= step_d;
`endif
      end
   end

   assign ball_x_o       = ball_x_q;
   assign ball_y_o       = ball_y_q;
   assign player_score_o = player_score_q;
   assign pc_score_o     = pc_score_q;

endmodule
